// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave: AXI scratch-memory slave with FIXED/INCR/WRAP bursts, byte strobes and SLVERR.
module axi_burst_mem_slave #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_BITS-1:0]   aw_addr,
  input  logic [LEN_BITS-1:0]    aw_len,
  input  logic [SIZE_BITS-1:0]   aw_size,
  input  logic [1:0]             aw_burst,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [DATA_BITS-1:0]   w_data,
  input  logic [DATA_BITS/8-1:0] w_strb,
  input  logic                   w_last,
  input  logic                   w_valid,
  output logic                   w_ready,
  output logic                   b_valid,
  output logic [1:0]             b_resp,
  input  logic                   b_ready,
  input  logic [ADDR_BITS-1:0]   ar_addr,
  input  logic [LEN_BITS-1:0]    ar_len,
  input  logic [SIZE_BITS-1:0]   ar_size,
  input  logic [1:0]             ar_burst,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  output logic [DATA_BITS-1:0]   r_data,
  output logic [1:0]             r_resp,
  output logic                   r_last,
  output logic                   r_valid,
  input  logic                   r_ready
);
  localparam int NB = DATA_BITS / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [LEN_BITS-1:0] len_t;
  localparam addr_t A1 = 1;
  localparam len_t L1 = 1;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rst_t;

  function automatic addr_t nxt(input addr_t a, input len_t l, input logic [SIZE_BITS-1:0] s, input logic [1:0] b);
    addr_t inc, ctr;
    inc = A1 << s;
    ctr = inc * (addr_t'(l) + A1);
    return b == 2'b00 ? a :
           b == 2'b10 ? (a & ~(ctr - A1)) | ((a + inc) & (ctr - A1)) : (a & ~(inc - A1)) + inc;
  endfunction

  function automatic logic ill(input addr_t a, input len_t l, input logic [SIZE_BITS-1:0] s, input logic [1:0] b);
    addr_t inc;
    inc = A1 << s;
    return int'(s) > OFF || b == 2'b11 ||
           (b == 2'b10 && (!(l inside {len_t'(1), len_t'(3), len_t'(7), len_t'(15)}) || (a & (inc - A1)) != '0));
  endfunction

  function automatic logic inr(input addr_t a);
    return (a >> OFF) < addr_t'(MEM_DEPTH);
  endfunction

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  wst_t ws_q, ws_d;
  rst_t rs_q, rs_d;
  logic aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d, werr_q, werr_d, wbad_q, wbad_d, we;
  logic [1:0] b_resp_q, b_resp_d, wburst_q, wburst_d, rburst_q, rburst_d, r_resp_q, r_resp_d;
  addr_t waddr_q, waddr_d, raddr_q, raddr_d, ra;
  len_t wlen_q, wlen_d, wcnt_q, wcnt_d, rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [SIZE_BITS-1:0] wsize_q, wsize_d, rsize_q, rsize_d;
  logic ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d, rbad_q, rbad_d, rok;
  logic [DATA_BITS-1:0] r_data_q, r_data_d, rword;

  always_comb begin
    ws_d = ws_q;
    aw_ready_d = aw_ready_q;
    w_ready_d = w_ready_q;
    b_valid_d = b_valid_q;
    b_resp_d = b_resp_q;
    waddr_d = waddr_q;
    wlen_d = wlen_q;
    wsize_d = wsize_q;
    wburst_d = wburst_q;
    wbad_d = wbad_q;
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    we = 1'b0;
    case (ws_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (aw_valid && aw_ready_q) begin
          wbad_d = ill(aw_addr, aw_len, aw_size, aw_burst);
          wburst_d = wbad_d ? 2'b01 : aw_burst;
          waddr_d = aw_addr;
          wlen_d = aw_len;
          wsize_d = aw_size;
          wcnt_d = '0;
          werr_d = 1'b0;
          aw_ready_d = 1'b0;
          w_ready_d = 1'b1;
          ws_d = W_DATA;
        end
      end
      W_DATA: if (w_valid && w_ready_q) begin
        we = inr(waddr_q) && !wbad_q;
        werr_d = werr_q || !we || (w_last != (wcnt_q == wlen_q));
        waddr_d = nxt(waddr_q, wlen_q, wsize_q, wburst_q);
        wcnt_d = wcnt_q + L1;
        if (wcnt_q == wlen_q) begin
          w_ready_d = 1'b0;
          b_valid_d = 1'b1;
          b_resp_d = werr_d ? 2'b10 : 2'b00;
          ws_d = W_RESP;
        end
      end
      default: if (b_ready) begin
        b_valid_d = 1'b0;
        aw_ready_d = 1'b1;
        ws_d = W_IDLE;
      end
    endcase
  end

  // Beat 0 is fetched straight off the AR bus so r_valid rises the cycle after the handshake.
  always_comb begin
    ra = rs_q == R_IDLE ? ar_addr : raddr_q;
    rok = inr(ra) && !(rs_q == R_IDLE ? ill(ar_addr, ar_len, ar_size, ar_burst) : rbad_q);
    rword = rok ? mem[IW'(ra >> OFF)] : '0;
    rs_d = rs_q;
    ar_ready_d = ar_ready_q;
    r_valid_d = r_valid_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_last_d = r_last_q;
    raddr_d = raddr_q;
    rlen_d = rlen_q;
    rsize_d = rsize_q;
    rburst_d = rburst_q;
    rbad_d = rbad_q;
    rcnt_d = rcnt_q;
    if (rs_q == R_IDLE) begin
      ar_ready_d = 1'b1;
      if (ar_valid && ar_ready_q) begin
        rbad_d = ill(ar_addr, ar_len, ar_size, ar_burst);
        rburst_d = rbad_d ? 2'b01 : ar_burst;
        raddr_d = nxt(ar_addr, ar_len, ar_size, rburst_d);
        rlen_d = ar_len;
        rsize_d = ar_size;
        rcnt_d = '0;
        ar_ready_d = 1'b0;
        r_valid_d = 1'b1;
        r_data_d = rword;
        r_resp_d = rok ? 2'b00 : 2'b10;
        r_last_d = ar_len == '0;
        rs_d = R_DATA;
      end
    end else if (r_ready) begin
      if (r_last_q) begin
        r_valid_d = 1'b0;
        r_last_d = 1'b0;
        ar_ready_d = 1'b1;
        rs_d = R_IDLE;
      end else begin
        r_data_d = rword;
        r_resp_d = rok ? 2'b00 : 2'b10;
        r_last_d = (rcnt_q + L1) == rlen_q;
        rcnt_d = rcnt_q + L1;
        raddr_d = nxt(raddr_q, rlen_q, rsize_q, rburst_q);
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < NB; i++)
      if (we && w_strb[i]) mem[IW'(waddr_q >> OFF)][i*8 +: 8] <= w_data[i*8 +: 8];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ws_q <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q <= 2'b00;
      waddr_q <= '0;
      wlen_q <= '0;
      wsize_q <= '0;
      wburst_q <= 2'b00;
      wbad_q <= 1'b0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
      rs_q <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= 2'b00;
      r_last_q <= 1'b0;
      raddr_q <= '0;
      rlen_q <= '0;
      rsize_q <= '0;
      rburst_q <= 2'b00;
      rbad_q <= 1'b0;
      rcnt_q <= '0;
    end else begin
      ws_q <= ws_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q <= w_ready_d;
      b_valid_q <= b_valid_d;
      b_resp_q <= b_resp_d;
      waddr_q <= waddr_d;
      wlen_q <= wlen_d;
      wsize_q <= wsize_d;
      wburst_q <= wburst_d;
      wbad_q <= wbad_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
      rs_q <= rs_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q <= r_valid_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      r_last_q <= r_last_d;
      raddr_q <= raddr_d;
      rlen_q <= rlen_d;
      rsize_q <= rsize_d;
      rburst_q <= rburst_d;
      rbad_q <= rbad_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready = w_ready_q;
  assign b_valid = b_valid_q;
  assign b_resp = b_resp_q;
  assign ar_ready = ar_ready_q;
  assign r_valid = r_valid_q;
  assign r_data = r_data_q;
  assign r_resp = r_resp_q;
  assign r_last = r_last_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb_axi_burst_mem_slave: vector table of write bursts with read-back through a model-fed scoreboard.
module tb_axi_burst_mem_slave;
  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] aw_addr = '0, ar_addr = '0, w_data = '0, r_data;
  logic [7:0] aw_len = '0, ar_len = '0;
  logic [2:0] aw_size = '0, ar_size = '0;
  logic [1:0] aw_burst = '0, ar_burst = '0, b_resp, r_resp;
  logic [3:0] w_strb = '0;
  logic aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready, b_valid, b_ready = 0;
  logic ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 0;

  always #5 aclk = ~aclk;

  axi_burst_mem_slave dut (
    .aclk(aclk), .areset(areset),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [31:0] d; logic [3:0] st; int last_at; logic [1:0] resp;} vec_t;
  typedef struct {logic [31:0] d; logic [1:0] r; logic l;} rexp_t;
  vec_t vt[13];
  rexp_t sb[$];
  logic [31:0] mdl [1024];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within 100 cycles (t=%0t)", nm, $time);
  endtask

  function automatic bit ill_f(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    return s > 3'd2 || b == 2'b11 || (b == 2'b10 && (!(l inside {8'd1, 8'd3, 8'd7, 8'd15}) || a % (32'd1 << s) != 0));
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input int k);
    logic [31:0] inc, ctr, base;
    inc = 32'd1 << s;
    if (ill_f(a, l, s, b)) b = 2'b01;
    if (b == 2'b00) return a;
    if (b == 2'b10) begin
      ctr = inc * (32'(l) + 32'd1);
      base = a - a % ctr;
      return base + (a - base + 32'(k) * inc) % ctr;
    end
    return k == 0 ? a : a - a % inc + 32'(k) * inc;
  endfunction

  task automatic do_write(input vec_t v);
    logic [31:0] ad;
    int t;
    aw_addr = v.a; aw_len = v.l; aw_size = v.s; aw_burst = v.b; aw_valid = 1;
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) tmo("aw_handshake");
    @(negedge aclk);
    aw_valid = 0;
    chk("w_ready_after_aw", w_ready, 1);
    for (int k = 0; k <= int'(v.l); k++) begin
      w_valid = 1; w_data = v.d + 32'(k); w_strb = v.st; w_last = (k == v.last_at);
      t = 0;
      while (!w_ready && t < 100) begin @(negedge aclk); t++; end
      if (t >= 100) tmo("w_handshake");
      @(negedge aclk);
      ad = baddr(v.a, v.l, v.s, v.b, k);
      if (!ill_f(v.a, v.l, v.s, v.b) && (ad >> 2) < 1024)
        for (int i = 0; i < 4; i++) if (v.st[i]) mdl[ad[11:2]][i*8 +: 8] = w_data[i*8 +: 8];
    end
    w_valid = 0; w_last = 0;
    chk("b_valid_latency", b_valid, 1);
    chk("b_resp", b_resp, v.resp);
    b_ready = 1;
    @(negedge aclk);
    b_ready = 0;
    chk("b_valid_drop", b_valid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input int stall_at);
    logic [31:0] ad;
    rexp_t e;
    int t;
    bit ok;
    for (int k = 0; k <= int'(l); k++) begin
      ad = baddr(a, l, s, b, k);
      ok = !ill_f(a, l, s, b) && (ad >> 2) < 1024;
      sb.push_back('{ok ? mdl[ad[11:2]] : 32'h0, ok ? 2'b00 : 2'b10, k == int'(l)});
    end
    ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_valid = 1; r_ready = 1;
    t = 0;
    while (!ar_ready && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) tmo("ar_handshake");
    @(negedge aclk);
    ar_valid = 0;
    chk("r_valid_after_ar", r_valid, 1);
    for (int k = 0; k <= int'(l); k++) begin
      t = 0;
      while (!r_valid && t < 100) begin @(negedge aclk); t++; end
      if (t >= 100) tmo("r_valid");
      e = sb.pop_front();
      chk("r_data", r_data, e.d);
      chk("r_resp", r_resp, e.r);
      chk("r_last", r_last, e.l);
      if (k == stall_at) begin
        r_ready = 0;
        repeat (3) begin
          @(negedge aclk);
          chk("r_data_stall", r_data, e.d);
          chk("r_last_stall", r_last, e.l);
        end
        r_ready = 1;
      end
      @(negedge aclk);
    end
    r_ready = 0;
    chk("r_valid_drop", r_valid, 0);
    chk("ar_ready_back", ar_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h10,  8'd3,   3'd2, 2'b01, 32'hA0,       4'hF,    3,   2'b00};
    vt[1]  = '{32'h40,  8'd0,   3'd2, 2'b01, 32'h12345678, 4'hF,    0,   2'b00};
    vt[2]  = '{32'h40,  8'd0,   3'd2, 2'b01, 32'hFFFFFFFF, 4'b0101, 0,   2'b00};
    vt[3]  = '{32'hFF8, 8'd3,   3'd2, 2'b01, 32'h33000000, 4'hF,    3,   2'b10};
    vt[4]  = '{32'h100, 8'd3,   3'd2, 2'b01, 32'hB0,       4'hF,    1,   2'b10};
    vt[5]  = '{32'h18,  8'd3,   3'd2, 2'b10, 32'hC0,       4'hF,    3,   2'b00};
    vt[6]  = '{32'h200, 8'd2,   3'd2, 2'b10, 32'hD0,       4'hF,    2,   2'b10};
    vt[7]  = '{32'h300, 8'd1,   3'd2, 2'b11, 32'hE0,       4'hF,    1,   2'b10};
    vt[8]  = '{32'h341, 8'd3,   3'd0, 2'b01, 32'hD0,       4'hF,    3,   2'b00};
    vt[9]  = '{32'h400, 8'd2,   3'd2, 2'b00, 32'hE0,       4'hF,    2,   2'b00};
    vt[10] = '{32'h500, 8'd0,   3'd3, 2'b01, 32'h55,       4'hF,    0,   2'b10};
    vt[11] = '{32'h1A,  8'd1,   3'd2, 2'b10, 32'h66,       4'hF,    1,   2'b10};
    vt[12] = '{32'h800, 8'd255, 3'd2, 2'b01, 32'h1000,     4'hF,    255, 2'b00};
    #1;
    chk("reset_outputs", {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_last, r_resp, r_data}, 0);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    chk("ready_after_reset", {aw_ready, ar_ready}, 2'b11);
    for (int i = 0; i < 13; i++) begin
      do_write(vt[i]);
      do_read(vt[i].a, vt[i].l, vt[i].s, vt[i].b, -1);
    end
    do_read(32'h10, 8'd3, 3'd2, 2'b01, -1);
    do_read(32'h18, 8'd3, 3'd2, 2'b10, -1);
    fork
      do_read(32'h100, 8'd3, 3'd2, 2'b01, 1);
      do_write('{32'h600, 8'd3, 3'd2, 2'b01, 32'hF0, 4'hF, 3, 2'b00});
    join
    do_read(32'h600, 8'd3, 3'd2, 2'b01, -1);
    aw_addr = 32'h700; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1;
    while (!aw_ready) @(negedge aclk);
    @(negedge aclk);
    aw_valid = 0; w_valid = 1; w_data = 32'h77; w_strb = 4'hF; w_last = 0;
    @(negedge aclk);
    w_valid = 0;
    mdl[10'h1C0] = 32'h77;
    #2 areset = 1;
    #1 chk("async_reset_outputs", {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_last, r_resp, r_data}, 0);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    chk("ready_after_midburst_reset", {aw_ready, ar_ready}, 2'b11);
    do_read(32'h700, 8'd0, 3'd2, 2'b01, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
- Parametrised AXI slave with on-chip memory; replaces the fixed-burst-only slave.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and per-byte write strobes.
- Returns SLVERR for out-of-range or illegal bursts.
- Write and read channels are independent FSMs sharing one memory array; the block sits behind the interconnect as a test/scratch memory target.

Parameters:
- DATA_BITS, 32, data bus width; power of 2, 32..256.
- ADDR_BITS, 32, byte address width.
- LEN_BITS, 8, burst length field width; beats = len+1.
- SIZE_BITS, 3, transfer size field width.
- MEM_DEPTH, 1024, memory depth in DATA_BITS words.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- aw_addr/aw_len/aw_size/aw_burst/aw_valid  in  ADDR_BITS/LEN_BITS/SIZE_BITS/2/1  write address channel.
- aw_ready  out  1  write address ready.
- w_data/w_strb/w_last/w_valid  in  DATA_BITS/DATA_BITS/8/1/1  write data channel.
- w_ready  out  1  write data ready.
- b_valid/b_resp  out  1/2  write response.
- b_ready  in  1  write response ready.
- ar_addr/ar_len/ar_size/ar_burst/ar_valid  in  ADDR_BITS/LEN_BITS/SIZE_BITS/2/1  read address channel.
- ar_ready  out  1  read address ready.
- r_data/r_resp/r_last/r_valid  out  DATA_BITS/2/1/1  read data channel.
- r_ready  in  1  read data ready.

Behaviour:
- Reset values:
  - aw_ready=0, w_ready=0, b_valid=0, b_resp=00, ar_ready=0, r_valid=0, r_last=0, r_resp=00, r_data=0.
  - aw_ready and ar_ready rise the first cycle after areset falls.
  - Memory contents are not reset.
- All outputs are registered. Reset asserted mid-burst aborts both FSMs to IDLE immediately; memory writes already committed persist.
- Word index = addr >> log2(DATA_BITS/8). Beat is in range iff index < MEM_DEPTH.
- Address generation per beat, with inc = 1<<size:
  - FIXED: addr unchanged.
  - INCR: addr = (addr & ~(inc-1)) + inc; the first beat may be unaligned.
  - WRAP: container = inc*(len+1); addr = base | ((addr+inc) & (container-1)), where base = addr & ~(container-1).
- Illegal bursts are executed as INCR and every beat responds SLVERR (2'b10):
  - size > log2(DATA_BITS/8);
  - burst=11;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned addr.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: aw_ready=1. On aw_valid, latch control, clear err, aw_ready<=0, w_ready<=1, go to W_DATA.
  - W_DATA: each w_valid&&w_ready beat writes byte lanes where w_strb[i]=1 at the current index. Writes are suppressed when the beat is out of range or the burst is illegal; either condition sets err.
  - Beat counter runs 0..len. w_last must equal (count==len); a mismatch sets err.
  - On the final beat: w_ready<=0, b_valid<=1, b_resp <= err ? 10 : 00, go to W_RESP. The burst ends on the count, not on w_last.
  - W_RESP: hold b_valid/b_resp until b_ready. Then b_valid<=0, aw_ready<=1, go to W_IDLE.
  - Minimum turnaround: AW handshake, first W accepted the next cycle, B valid the cycle after the last W.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ar_ready=1. On ar_valid, latch control, ar_ready<=0. Next cycle: r_valid=1, r_data = mem[index] for beat 0, r_last = (len==0).
  - R_DATA: r_data/r_resp/r_last are held stable while r_valid && !r_ready.
  - On r_ready, load the next beat on the following edge, so full throughput is one beat per cycle.
  - Out-of-range or illegal beat: r_data=0, r_resp=10. Otherwise r_resp=00.
  - After the r_last beat handshakes: r_valid<=0, ar_ready<=1, go to R_IDLE.
- Simultaneous read and write to the same word in one cycle: the read returns the old contents (read-before-write).
- The channels run fully concurrently; neither stalls the other.
- Beat counters are LEN_BITS wide; len=255 gives 256 beats with no overflow.

Test Plan:
- Reset released; INCR write addr=0x10, len=3, size=2 (32-bit), data 0xA0..0xA3, strb=F -> words 4..7 written; b_resp=00 one cycle after the last W. Then an INCR read of the same burst -> r_data A0,A1,A2,A3; r_last only on beat 3.
- WRAP read addr=0x18, len=3, size=2 -> addresses 0x18,0x1C,0x10,0x14; r_resp=00.
- Write w_strb=4'b0101, data 0xFFFFFFFF over 0x12345678 -> readback 0x12FF56FF.
- INCR write starting at word 1022, len=3 -> words 1022,1023 written; 1024,1025 suppressed; b_resp=10. A read of the same range -> beats 2,3 give r_data=0, r_resp=10.
- Read with r_ready low for 3 cycles mid-burst -> r_data/r_last stable throughout. Concurrent write burst completes unaffected.
- w_last asserted on beat 1 of a len=3 burst -> all 4 beats accepted, b_resp=10. areset pulsed mid-burst -> all outputs return to reset values asynchronously.
